// File: rtl/ghost_regbank_pkg.sv
// Shared constants, address-region enum and decode helpers for the ghost register bank.
package ghost_regbank_pkg;

   localparam int          READ_LATENCY = 2;
   localparam int unsigned CTRL_OFS     = 0;

   typedef enum logic [1:0] {CTRL, CNT, RAM, NONE} region_e;

   function automatic int unsigned cnt_ofs(input int unsigned nreg);
      return CTRL_OFS + nreg;
   endfunction

   // Counters sit directly after the control registers; RAM lives at its own base.
   function automatic region_e decode_region(input logic [63:0] addr,
                                             input int unsigned nreg,
                                             input int unsigned nch,
                                             input int unsigned ram_base,
                                             input int unsigned rd);
      if (addr < 64'(cnt_ofs(nreg)))
         return CTRL;
      if (addr < 64'(cnt_ofs(nreg) + nch))
         return CNT;
      if (addr >= 64'(ram_base) && addr < 64'(ram_base) + 64'(rd))
         return RAM;
      return NONE;
   endfunction

   function automatic int unsigned region_base(input region_e r,
                                               input int unsigned nreg,
                                               input int unsigned ram_base);
      case (r)
         CTRL:    return CTRL_OFS;
         CNT:     return cnt_ofs(nreg);
         RAM:     return ram_base;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/ghost_regbank_evcnt.sv
// Saturating event counter with clear-on-read; an event during the clear leaves it at 1.
module ghost_evcnt
   import ghost_regbank_pkg::*;
#(
   parameter int GW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ev,
   input  logic          clr,
   output logic [GW-1:0] count
);

   localparam logic [GW-1:0] MAX = '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= ev ? GW'(1) : '0;
      else if (ev && count != MAX)
         count <= count + GW'(1);
   end

endmodule

// File: rtl/ghost_regbank.sv
// Host-mapped bank of control registers, clear-on-read event counters and a dual-read RAM.
module ghost_regbank
   import ghost_regbank_pkg::*;
#(
   parameter int AW        = 24,
   parameter int DW        = 32,
   parameter int GW        = 8,
   parameter int NREG      = 4,
   parameter int NCH       = 2,
   parameter int RD        = 8,
   parameter int RAM_BASE  = 'h40,
   parameter int CTRL_INIT = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [AW-1:0]           gb_addr,
   input  logic [DW-1:0]           gb_wdata,
   input  logic                    gb_we,
   input  logic                    gb_re,
   output logic [DW-1:0]           gb_rdata,
   output logic                    gb_rvalid,
   output logic [NREG*GW-1:0]      ctrl,
   output logic [NREG-1:0]         ctrl_ws,
   output logic [NREG-1:0]         ctrl_rs,
   input  logic [NCH-1:0]          ev,
   input  logic [$clog2(RD)-1:0]   lram_addr,
   output logic [GW-1:0]           lram_data
);

   localparam int RAW = $clog2(RD);

   if (GW > DW) begin : g_chk_gw
      $error("ghost_regbank: GW must not exceed DW");
   end
   if ((RD & (RD - 1)) != 0) begin : g_chk_rd
      $error("ghost_regbank: RD must be a power of two");
   end
   if ((RAM_BASE % RD) != 0) begin : g_chk_base
      $error("ghost_regbank: RAM_BASE must be RD-aligned");
   end
   if (DW > GW) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^gb_wdata[DW-1:GW];
   end

   logic [GW-1:0]  ctrl_q  [NREG];
   logic [GW-1:0]  cnt_val [NCH];
   logic [NCH-1:0] cnt_clr;
   logic [GW-1:0]  ram_mem [RD];

   logic [63:0]    addr_ext;
   region_e        region;
   logic [31:0]    idx;
   logic [RAW-1:0] ram_idx;
   logic [DW-1:0]  rd_mux;

   always_comb begin
      addr_ext = 64'(gb_addr);
      region   = decode_region(addr_ext, NREG, NCH, RAM_BASE, RD);
      idx      = 32'(addr_ext - 64'(region_base(region, NREG, RAM_BASE)));
      ram_idx  = idx[RAW-1:0];
   end

   // Read data is taken from the pre-edge state, giving read-before-write on collisions.
   always_comb begin
      rd_mux = '0;
      case (region)
         CTRL:
            for (int i = 0; i < NREG; i++)
               if (idx == 32'(i))
                  rd_mux = DW'(ctrl_q[i]);
         CNT:
            for (int c = 0; c < NCH; c++)
               if (idx == 32'(c))
                  rd_mux = DW'(cnt_val[c]);
         RAM:
            rd_mux = DW'(ram_mem[ram_idx]);
         default: ;
      endcase
   end

   always_comb begin
      cnt_clr = '0;
      for (int c = 0; c < NCH; c++)
         if (gb_re && region == CNT && idx == 32'(c))
            cnt_clr[c] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            ctrl_q[i] <= GW'(CTRL_INIT);
         ctrl_ws <= '0;
         ctrl_rs <= '0;
      end else begin
         ctrl_ws <= '0;
         ctrl_rs <= '0;
         for (int i = 0; i < NREG; i++) begin
            if (gb_we && region == CTRL && idx == 32'(i)) begin
               ctrl_q[i]  <= gb_wdata[GW-1:0];
               ctrl_ws[i] <= 1'b1;
            end
            if (gb_re && region == CTRL && idx == 32'(i))
               ctrl_rs[i] <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NREG; i++) begin : g_ctrl
      assign ctrl[i*GW +: GW] = ctrl_q[i];
   end

   for (genvar c = 0; c < NCH; c++) begin : g_cnt
      ghost_evcnt #(.GW(GW)) u_evcnt (
         .clk   (clk),
         .rst_n (rst_n),
         .ev    (ev[c]),
         .clr   (cnt_clr[c]),
         .count (cnt_val[c])
      );
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (gb_we && region == RAM)
         ram_mem[ram_idx] <= gb_wdata[GW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lram_data <= '0;
      else
         lram_data <= ram_mem[lram_addr];
   end

   // Capture stage followed by READ_LATENCY delay stages; reset flushes anything in flight.
   logic          cap_valid;
   logic [DW-1:0] cap_data;
   logic          pipe_valid [READ_LATENCY];
   logic [DW-1:0] pipe_data  [READ_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid <= 1'b0;
         cap_data  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_data[i]  <= '0;
         end
      end else begin
         cap_valid     <= gb_re;
         cap_data      <= gb_re ? rd_mux : '0;
         pipe_valid[0] <= cap_valid;
         pipe_data[0]  <= cap_data;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   assign gb_rvalid = pipe_valid[READ_LATENCY-1];
   assign gb_rdata  = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_ghost_regbank.sv
// Directed self-checking bench for ghost_regbank with hand-computed expectations.
module tb_ghost_regbank;

   logic        clk;
   logic        rst_n;
   logic [23:0] gb_addr;
   logic [31:0] gb_wdata;
   logic        gb_we;
   logic        gb_re;
   logic [31:0] gb_rdata;
   logic        gb_rvalid;
   logic [31:0] ctrl;
   logic [3:0]  ctrl_ws;
   logic [3:0]  ctrl_rs;
   logic [1:0]  ev;
   logic [2:0]  lram_addr;
   logic [7:0]  lram_data;

   int checks   = 0;
   int failures = 0;

   ghost_regbank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gb_addr   (gb_addr),
      .gb_wdata  (gb_wdata),
      .gb_we     (gb_we),
      .gb_re     (gb_re),
      .gb_rdata  (gb_rdata),
      .gb_rvalid (gb_rvalid),
      .ctrl      (ctrl),
      .ctrl_ws   (ctrl_ws),
      .ctrl_rs   (ctrl_rs),
      .ev        (ev),
      .lram_addr (lram_addr),
      .lram_data (lram_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hostWrite(input logic [23:0] addr, input logic [31:0] data);
      gb_addr  = addr;
      gb_wdata = data;
      gb_we    = 1'b1;
      tick();
      gb_we    = 1'b0;
   endtask

   // One read (optionally with a coincident write/event); checks strobe, latency and data.
   task automatic applyStimulus(input logic [23:0] addr, input logic we, input logic [31:0] wdata,
                                input logic [1:0] evv, input logic [3:0] exp_rs,
                                input logic [31:0] exp, input string tag);
      gb_addr  = addr;
      gb_re    = 1'b1;
      gb_we    = we;
      gb_wdata = wdata;
      ev       = evv;
      tick();
      gb_re = 1'b0;
      gb_we = 1'b0;
      ev    = 2'b00;
      checkOutput({tag, "_rs"}, 64'(ctrl_rs), 64'(exp_rs));
      checkOutput({tag, "_rv_n1"}, 64'(gb_rvalid), 64'd0);
      tick();
      checkOutput({tag, "_rv_n2"}, 64'(gb_rvalid), 64'd0);
      tick();
      checkOutput({tag, "_rv"}, 64'(gb_rvalid), 64'd1);
      checkOutput({tag, "_data"}, 64'(gb_rdata), 64'(exp));
   endtask

   initial begin
      rst_n     = 1'b1;
      gb_addr   = '0;
      gb_wdata  = '0;
      gb_we     = 1'b0;
      gb_re     = 1'b0;
      ev        = 2'b00;
      lram_addr = '0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      checkOutput("rst_ctrl", 64'(ctrl), 64'd0);
      checkOutput("rst_rvalid", 64'(gb_rvalid), 64'd0);
      checkOutput("rst_rdata", 64'(gb_rdata), 64'd0);
      checkOutput("rst_ws_rs", 64'({ctrl_ws, ctrl_rs}), 64'd0);
      checkOutput("rst_lram", 64'(lram_data), 64'd0);

      // Write accepted on the very first edge after reset release.
      rst_n = 1'b1;
      hostWrite(24'h1, 32'h5A);
      checkOutput("wr1_ws", 64'(ctrl_ws), 64'b0010);
      checkOutput("wr1_ctrl", 64'(ctrl), 64'h0000_5A00);
      tick();
      checkOutput("wr1_ws_off", 64'(ctrl_ws), 64'd0);
      applyStimulus(24'h1, 1'b0, 32'h0, 2'b00, 4'b0010, 32'h0000_005A, "rd1");

      // Saturation and clear-on-read.
      ev = 2'b01;
      repeat (300) tick();
      ev = 2'b00;
      applyStimulus(24'h4, 1'b0, 32'h0, 2'b00, 4'b0000, 32'hFF, "sat");
      applyStimulus(24'h4, 1'b0, 32'h0, 2'b00, 4'b0000, 32'h0, "sat_reread");

      // Event coincident with the clearing read.
      ev = 2'b10;
      repeat (7) tick();
      ev = 2'b00;
      applyStimulus(24'h5, 1'b0, 32'h0, 2'b10, 4'b0000, 32'h7, "coinc");
      applyStimulus(24'h5, 1'b0, 32'h0, 2'b00, 4'b0000, 32'h1, "coinc_next");

      // Read-before-write on the same control register.
      applyStimulus(24'h2, 1'b1, 32'h33, 2'b00, 4'b0100, 32'h0, "rbw");
      checkOutput("rbw_ctrl", 64'(ctrl), 64'h0033_5A00);

      // Writes to counters and unmapped space are ignored.
      hostWrite(24'h10, 32'hFF);
      hostWrite(24'h4, 32'hAA);
      checkOutput("ign_ctrl", 64'(ctrl), 64'h0033_5A00);
      applyStimulus(24'h4, 1'b0, 32'h0, 2'b00, 4'b0000, 32'h0, "ign_cnt");

      // RAM writes truncate to GW; three back-to-back reads.
      hostWrite(24'h44, 32'h21);
      hostWrite(24'h43, 32'h109);
      gb_re = 1'b1;
      gb_addr = 24'h43;
      tick();
      gb_addr = 24'h44;
      tick();
      gb_addr = 24'h10;
      tick();
      gb_re = 1'b0;
      checkOutput("b2b_rv0", 64'(gb_rvalid), 64'd1);
      checkOutput("b2b_d0", 64'(gb_rdata), 64'h9);
      tick();
      checkOutput("b2b_rv1", 64'(gb_rvalid), 64'd1);
      checkOutput("b2b_d1", 64'(gb_rdata), 64'h21);
      tick();
      checkOutput("b2b_rv2", 64'(gb_rvalid), 64'd1);
      checkOutput("b2b_d2", 64'(gb_rdata), 64'h0);
      tick();
      checkOutput("b2b_rv_off", 64'(gb_rvalid), 64'd0);

      // Local read port, including a same-word collision with a host write.
      lram_addr = 3'd3;
      tick();
      checkOutput("lram_3", 64'(lram_data), 64'h9);
      hostWrite(24'h45, 32'h55);
      lram_addr = 3'd5;
      hostWrite(24'h45, 32'h66);
      checkOutput("lram_old", 64'(lram_data), 64'h55);
      tick();
      checkOutput("lram_new", 64'(lram_data), 64'h66);

      // Reset one cycle after a read request flushes it and restores defaults.
      ev = 2'b01;
      repeat (3) tick();
      ev = 2'b00;
      gb_addr = 24'h1;
      gb_re   = 1'b1;
      tick();
      gb_re = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("mid_rst_rv", 64'(gb_rvalid), 64'd0);
      end
      checkOutput("mid_rst_ctrl", 64'(ctrl), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post_rst_rv", 64'(gb_rvalid), 64'd0);
      end
      applyStimulus(24'h4, 1'b0, 32'h0, 2'b00, 4'b0000, 32'h0, "post_cnt0");
      applyStimulus(24'h5, 1'b0, 32'h0, 2'b00, 4'b0000, 32'h0, "post_cnt1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
